// File: rtl/buffer_sequencer_if.sv
// Column and patch handshakes between the line-buffer sequencer, the upstream column source
// and the downstream patch consumer.
interface buffer_sequencer_if #(
   parameter int BUF_HEIGHT = 8,
   parameter int BUF_WIDTH  = 34
);
   localparam int XW = $clog2(BUF_WIDTH);

   logic                  col_valid;
   logic [BUF_HEIGHT-1:0] col_data;
   logic                  col_ready;
   logic                  patch_valid;
   logic                  patch_ready;
   logic [XW-1:0]         patch_x;
   logic [7:0]            patch_y;
   logic                  patch_eol;

   modport master (
      input  col_valid, col_data, patch_ready,
      output col_ready, patch_valid, patch_x, patch_y, patch_eol
   );

   modport slave (
      output col_valid, col_data, patch_ready,
      input  col_ready, patch_valid, patch_x, patch_y, patch_eol
   );
endinterface

// File: rtl/buffer_sequencer.sv
// Sliding-window line-buffer controller: accepts columns, strobes buffer shifts and emits
// one (x, y) patch descriptor per complete kernel window, stalling while a patch is unconsumed.
module buffer_sequencer #(
   parameter int BUF_HEIGHT      = 8,
   parameter int BUF_WIDTH       = 34,
   parameter int MAX_KERNEL_SIZE = 7
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [$clog2(BUF_WIDTH)-1:0]         img_width,
   input  logic [$clog2(MAX_KERNEL_SIZE+1)-1:0] kernel_size,
   input  logic [7:0]                           num_bands,
   buffer_sequencer_if.master                   bus,
   output logic                                 shift_enable,
   output logic [BUF_HEIGHT-1:0]                pixel_out,
   output logic                                 done,
   output logic                                 busy,
   output logic                                 err
);
   localparam int XW = $clog2(BUF_WIDTH);
   localparam int KW = $clog2(MAX_KERNEL_SIZE+1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state;
   logic [XW-1:0] w_q;
   logic [KW-1:0] k_q;
   logic [7:0]    b_q;
   logic [XW-1:0] col_cnt;
   logic [7:0]    band_cnt;
   logic          pv_q;
   logic [XW-1:0] px_q;
   logic [7:0]    py_q;
   logic          peol_q;

   logic          cfg_bad;
   logic          accept;
   logic          stalled;
   logic [XW-1:0] wm1;
   logic [XW-1:0] km1;

   // Legality is evaluated at 32 bits so the limits cannot alias at the port widths.
   assign cfg_bad = (img_width == '0) || (kernel_size == '0) ||
                    (32'(kernel_size) > 32'(MAX_KERNEL_SIZE)) ||
                    (32'(kernel_size) > 32'(img_width)) ||
                    (32'(img_width) > 32'(BUF_WIDTH - 1)) ||
                    (num_bands == '0);

   assign wm1     = w_q - XW'(1);
   assign km1     = XW'(k_q) - XW'(1);
   assign stalled = pv_q && !bus.patch_ready;

   assign bus.col_ready   = (state == S_RUN) && !stalled;
   assign accept          = bus.col_valid && bus.col_ready;
   assign shift_enable    = accept;
   assign pixel_out       = bus.col_data;
   assign busy            = (state == S_RUN) || (state == S_DRAIN);
   assign bus.patch_valid = pv_q;
   assign bus.patch_x     = px_q;
   assign bus.patch_y     = py_q;
   assign bus.patch_eol   = peol_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         w_q      <= '0;
         k_q      <= '0;
         b_q      <= '0;
         col_cnt  <= '0;
         band_cnt <= '0;
         pv_q     <= 1'b0;
         px_q     <= '0;
         py_q     <= '0;
         peol_q   <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  w_q      <= img_width;
                  k_q      <= kernel_size;
                  b_q      <= num_bands;
                  col_cnt  <= '0;
                  band_cnt <= '0;
                  err      <= cfg_bad;
                  done     <= cfg_bad;
                  state    <= cfg_bad ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (col_cnt == wm1) begin
                     col_cnt  <= '0;
                     band_cnt <= band_cnt + 8'd1;
                     if (band_cnt == b_q - 8'd1) state <= S_DRAIN;
                  end else begin
                     col_cnt <= col_cnt + XW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (!pv_q || bus.patch_ready) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase

         // A fresh load wins over the consume of the previous patch in the same cycle.
         if (accept && (col_cnt >= km1)) begin
            pv_q   <= 1'b1;
            px_q   <= col_cnt - km1;
            py_q   <= band_cnt;
            peol_q <= (col_cnt == wm1);
         end else if (pv_q && bus.patch_ready) begin
            pv_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_buffer_sequencer.sv
// Directed bench for buffer_sequencer: patch sequences, backpressure, illegal config,
// start while busy, mid-image reset and upstream gaps.
module tb_buffer_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [5:0] img_width;
   logic [2:0] kernel_size;
   logic [7:0] num_bands;
   logic       shift_enable;
   logic [7:0] pixel_out;
   logic       done;
   logic       busy;
   logic       err;

   buffer_sequencer_if #(.BUF_HEIGHT(8), .BUF_WIDTH(34)) bus ();

   buffer_sequencer #(
      .BUF_HEIGHT(8),
      .BUF_WIDTH(34),
      .MAX_KERNEL_SIZE(7)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .img_width(img_width),
      .kernel_size(kernel_size),
      .num_bands(num_bands),
      .bus(bus),
      .shift_enable(shift_enable),
      .pixel_out(pixel_out),
      .done(done),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int qx[$];
   int qy[$];
   int qe[$];
   int shift_cnt      = 0;
   int cyc            = 0;
   int last_shift_cyc = -1;
   int done_rise_cyc  = -1;
   logic done_prev    = 1'b0;

   // Observer on the falling edge: records accepted columns and consumed patches.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (shift_enable) begin
         shift_cnt      = shift_cnt + 1;
         last_shift_cyc = cyc;
      end
      if (bus.patch_valid && bus.patch_ready) begin
         qx.push_back(int'(bus.patch_x));
         qy.push_back(int'(bus.patch_y));
         qe.push_back(int'(bus.patch_eol));
      end
      if (done && !done_prev) done_rise_cyc = cyc;
      done_prev = done;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      qx.delete();
      qy.delete();
      qe.delete();
      shift_cnt      = 0;
      last_shift_cyc = -1;
      done_rise_cyc  = -1;
   endtask

   task automatic do_start(input int w, input int k, input int b);
      @(posedge clk); #1;
      start       = 1'b1;
      img_width   = 6'(w);
      kernel_size = 3'(k);
      num_bands   = 8'(b);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int budget;
      budget = 200;
      while (!done && budget > 0) begin
         @(negedge clk); #1;
         budget--;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_timeout: done=%0b required 1 within 200 cycles", name, done);
      end
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      img_width = '0;
      kernel_size = '0;
      num_bands = '0;
      bus.col_valid = 1'b0;
      bus.col_data = '0;
      bus.patch_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (dut.state !== 2'd0) begin
         n_fail++; $display("FAIL reset_state: got %0d required 0", dut.state);
      end
      n_tests++;
      if ({bus.col_ready, shift_enable, bus.patch_valid, bus.patch_eol, done, busy, err} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: ready=%0b shift=%0b pv=%0b eol=%0b done=%0b busy=%0b err=%0b required all 0",
                  bus.col_ready, shift_enable, bus.patch_valid, bus.patch_eol, done, busy, err);
      end
      n_tests++;
      if (bus.patch_x !== 6'd0 || bus.patch_y !== 8'd0) begin
         n_fail++; $display("FAIL reset_xy: x=%0d y=%0d required 0 0", bus.patch_x, bus.patch_y);
      end
   endtask

   task automatic test_basic();
      int idx;
      clear_mon();
      bus.col_valid = 1'b1;
      bus.col_data = 8'hA5;
      bus.patch_ready = 1'b1;
      do_start(5, 3, 2);
      @(negedge clk);
      n_tests++;
      if (pixel_out !== 8'hA5 || shift_enable !== 1'b1) begin
         n_fail++; $display("FAIL basic_pixel: pixel_out=%h shift=%0b required a5 1", pixel_out, shift_enable);
      end
      wait_done("basic");
      n_tests++;
      if (shift_cnt != 10) begin
         n_fail++; $display("FAIL basic_shifts: got %0d required 10", shift_cnt);
      end
      n_tests++;
      if (qx.size() != 6) begin
         n_fail++; $display("FAIL basic_patch_count: got %0d required 6", qx.size());
      end else begin
         idx = 0;
         for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 3; x++) begin
               n_tests++;
               if (qx[idx] != x || qy[idx] != y || qe[idx] != int'(x == 2)) begin
                  n_fail++;
                  $display("FAIL basic_patch%0d: got (%0d,%0d,eol=%0d) required (%0d,%0d,eol=%0d)",
                           idx, qx[idx], qy[idx], qe[idx], x, y, int'(x == 2));
               end
               idx++;
            end
         end
      end
      n_tests++;
      if (done_rise_cyc - last_shift_cyc != 2) begin
         n_fail++;
         $display("FAIL basic_done_latency: got %0d cycles required 2", done_rise_cyc - last_shift_cyc);
      end
      n_tests++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_err_busy: err=%0b busy=%0b required 0 0", err, busy);
      end
   endtask

   task automatic test_backpressure();
      int budget;
      clear_mon();
      bus.col_valid = 1'b1;
      bus.patch_ready = 1'b0;
      do_start(6, 2, 1);
      budget = 20;
      @(negedge clk);
      while (!bus.patch_valid && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_tests++;
      if (!bus.patch_valid) begin
         n_fail++; $display("FAIL bp_first_patch: patch_valid=0 required 1 within 20 cycles");
      end
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         n_tests++;
         if (bus.col_ready !== 1'b0 || shift_enable !== 1'b0 || bus.patch_x !== 6'd0 || bus.patch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall%0d: ready=%0b shift=%0b x=%0d pv=%0b required 0 0 0 1",
                     i, bus.col_ready, shift_enable, bus.patch_x, bus.patch_valid);
         end
      end
      @(posedge clk); #1;
      bus.patch_ready = 1'b1;
      wait_done("bp");
      n_tests++;
      if (shift_cnt != 6) begin
         n_fail++; $display("FAIL bp_shifts: got %0d required 6", shift_cnt);
      end
      n_tests++;
      if (qx.size() != 5) begin
         n_fail++; $display("FAIL bp_patch_count: got %0d required 5", qx.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (qx[i] != i || qy[i] != 0 || qe[i] != int'(i == 4)) begin
               n_fail++;
               $display("FAIL bp_patch%0d: got (%0d,%0d,eol=%0d) required (%0d,0,eol=%0d)",
                        i, qx[i], qy[i], qe[i], i, int'(i == 4));
            end
         end
      end
   endtask

   task automatic test_illegal();
      int w_tab[2] = '{3, 5};
      int k_tab[2] = '{4, 3};
      int b_tab[2] = '{1, 0};
      bus.col_valid = 1'b1;
      bus.patch_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         clear_mon();
         do_start(w_tab[c], k_tab[c], b_tab[c]);
         @(negedge clk);
         n_tests++;
         if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || dut.state !== 2'd3) begin
            n_fail++;
            $display("FAIL illegal%0d_status: done=%0b err=%0b busy=%0b state=%0d required 1 1 0 3",
                     c, done, err, busy, dut.state);
         end
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.col_ready !== 1'b0 || shift_enable !== 1'b0) begin
               n_fail++;
               $display("FAIL illegal%0d_ready: ready=%0b shift=%0b required 0 0", c, bus.col_ready, shift_enable);
            end
            @(negedge clk);
         end
         n_tests++;
         if (shift_cnt != 0) begin
            n_fail++; $display("FAIL illegal%0d_shifts: got %0d required 0", c, shift_cnt);
         end
      end
   endtask

   task automatic test_start_busy();
      clear_mon();
      bus.col_valid = 1'b1;
      bus.patch_ready = 1'b1;
      do_start(5, 3, 2);
      @(negedge clk);
      n_tests++;
      if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_clear: err=%0b done=%0b busy=%0b required 0 0 1", err, done, busy);
      end
      repeat (2) @(posedge clk);
      do_start(4, 2, 1);
      wait_done("busy");
      n_tests++;
      if (qx.size() != 6 || shift_cnt != 10) begin
         n_fail++; $display("FAIL busy_ignored: patches=%0d shifts=%0d required 6 10", qx.size(), shift_cnt);
      end else begin
         n_tests++;
         if (qx[5] != 2 || qy[5] != 1 || qe[5] != 1) begin
            n_fail++; $display("FAIL busy_last: got (%0d,%0d,%0d) required (2,1,1)", qx[5], qy[5], qe[5]);
         end
      end
      clear_mon();
      do_start(4, 2, 1);
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL restart_status: done=%0b err=%0b busy=%0b required 0 0 1", done, err, busy);
      end
      wait_done("restart");
      n_tests++;
      if (qx.size() != 3 || shift_cnt != 4) begin
         n_fail++; $display("FAIL restart_count: patches=%0d shifts=%0d required 3 4", qx.size(), shift_cnt);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (qx[i] != i || qy[i] != 0 || qe[i] != int'(i == 2)) begin
               n_fail++;
               $display("FAIL restart_patch%0d: got (%0d,%0d,%0d) required (%0d,0,%0d)",
                        i, qx[i], qy[i], qe[i], i, int'(i == 2));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int budget;
      clear_mon();
      bus.col_valid = 1'b1;
      bus.patch_ready = 1'b1;
      do_start(5, 3, 2);
      budget = 50;
      @(negedge clk); #1;
      while (shift_cnt < 7 && budget > 0) begin
         @(negedge clk); #1;
         budget--;
      end
      n_tests++;
      if (shift_cnt != 7) begin
         n_fail++; $display("FAIL rstmid_accepts: got %0d required 7", shift_cnt);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      bus.col_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (dut.state !== 2'd0 || dut.col_cnt !== 6'd0 || dut.band_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL rstmid_state: state=%0d col=%0d band=%0d required 0 0 0", dut.state, dut.col_cnt, dut.band_cnt);
      end
      n_tests++;
      if ({bus.col_ready, shift_enable, bus.patch_valid, bus.patch_eol, done, busy, err} !== 7'b0 ||
          bus.patch_x !== 6'd0 || bus.patch_y !== 8'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: ready=%0b pv=%0b eol=%0b done=%0b busy=%0b err=%0b x=%0d y=%0d required all 0",
                  bus.col_ready, bus.patch_valid, bus.patch_eol, done, busy, err, bus.patch_x, bus.patch_y);
      end
      clear_mon();
      bus.col_valid = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (qx.size() != 0 || shift_cnt != 0) begin
         n_fail++; $display("FAIL rstmid_quiet: patches=%0d shifts=%0d required 0 0", qx.size(), shift_cnt);
      end
      do_start(5, 3, 2);
      wait_done("rstmid");
      n_tests++;
      if (qx.size() != 6) begin
         n_fail++; $display("FAIL rstmid_count: got %0d required 6", qx.size());
      end else begin
         n_tests++;
         if (qx[0] != 0 || qy[0] != 0 || qx[3] != 0 || qy[3] != 1) begin
            n_fail++;
            $display("FAIL rstmid_order: first (%0d,%0d) fourth (%0d,%0d) required (0,0) (0,1)",
                     qx[0], qy[0], qx[3], qy[3]);
         end
      end
   endtask

   task automatic test_gaps();
      clear_mon();
      bus.col_valid = 1'b0;
      bus.patch_ready = 1'b1;
      do_start(4, 4, 1);
      for (int i = 0; i < 8; i++) begin
         bus.col_valid = (i % 2 == 0);
         @(negedge clk);
         if (i == 1 || i == 3 || i == 5) begin
            n_tests++;
            if (shift_enable !== 1'b0 || int'(dut.col_cnt) != (i + 1) / 2 || bus.patch_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL gap%0d: shift=%0b col_cnt=%0d pv=%0b required 0 %0d 0",
                        i, shift_enable, dut.col_cnt, bus.patch_valid, (i + 1) / 2);
            end
         end
         @(posedge clk); #1;
      end
      bus.col_valid = 1'b0;
      wait_done("gaps");
      n_tests++;
      if (shift_cnt != 4 || qx.size() != 1) begin
         n_fail++; $display("FAIL gaps_count: shifts=%0d patches=%0d required 4 1", shift_cnt, qx.size());
      end else begin
         n_tests++;
         if (qx[0] != 0 || qy[0] != 0 || qe[0] != 1) begin
            n_fail++; $display("FAIL gaps_patch: got (%0d,%0d,%0d) required (0,0,1)", qx[0], qy[0], qe[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_illegal();
      test_start_busy();
      test_reset_mid();
      test_gaps();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
